// File: rtl/oreg_arbiter.sv
// Two-master arbiter for the peripheral instruction bus (oreg / oreg_wen).
// Round-robin on conflict, per-target ready and post-issue guard masking, registered outputs.
module oreg_arbiter #(
    parameter int InstWidth   = 12,
    parameter int TargetCount = 8,
    parameter int GuardCycles = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [InstWidth-1:0]   m0_oreg,
    input  logic [TargetCount-1:0] m0_oreg_wen,
    output logic                   m0_grant,
    input  logic [InstWidth-1:0]   m1_oreg,
    input  logic [TargetCount-1:0] m1_oreg_wen,
    output logic                   m1_grant,
    input  logic [TargetCount-1:0] tgt_ready,
    output logic [InstWidth-1:0]   oreg,
    output logic [TargetCount-1:0] oreg_wen
);

    localparam logic [3:0] GuardLoad = 4'(GuardCycles);

    logic [TargetCount-1:0] tgt_open;
    logic                   m0_valid;
    logic                   m1_valid;
    logic                   m0_elig;
    logic                   m1_elig;
    logic                   sel_m1;
    logic                   issue;
    logic [InstWidth-1:0]   oreg_next;
    logic [TargetCount-1:0] oreg_wen_next;

    logic [InstWidth-1:0]   oreg_reg;
    logic [TargetCount-1:0] oreg_wen_reg;
    logic                   m0_grant_reg;
    logic                   m1_grant_reg;
    logic                   last_m1_reg;

    // A target is usable only when it is ready and its guard window has expired.
    generate
        for (genvar gi = 0; gi < TargetCount; gi++) begin : g_tgt
            logic [3:0] guard_reg;

            assign tgt_open[gi] = tgt_ready[gi] && (guard_reg == 4'd0);

            always_ff @(posedge clock) begin
                if (reset) begin
                    guard_reg <= 4'd0;
                end else if (issue && oreg_wen_next[gi]) begin
                    guard_reg <= GuardLoad;
                end else if (guard_reg != 4'd0) begin
                    guard_reg <= guard_reg - 4'd1;
                end
            end
        end
    endgenerate

    always_comb begin
        m0_valid      = |m0_oreg_wen;
        m1_valid      = |m1_oreg_wen;
        // A master whose grant is visible is excluded so a held command cannot issue twice.
        m0_elig       = m0_valid && !m0_grant_reg && ((m0_oreg_wen & ~tgt_open) == '0);
        m1_elig       = m1_valid && !m1_grant_reg && ((m1_oreg_wen & ~tgt_open) == '0);
        issue         = m0_elig || m1_elig;
        sel_m1        = 1'b0;
        oreg_next     = m0_oreg;
        oreg_wen_next = '0;
        if (m0_elig && m1_elig) begin
            sel_m1 = !last_m1_reg;
        end else begin
            sel_m1 = m1_elig;
        end
        if (sel_m1) begin
            oreg_next = m1_oreg;
        end
        if (issue) begin
            oreg_wen_next = sel_m1 ? m1_oreg_wen : m0_oreg_wen;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            oreg_reg     <= '0;
            oreg_wen_reg <= '0;
            m0_grant_reg <= 1'b0;
            m1_grant_reg <= 1'b0;
            last_m1_reg  <= 1'b1;
        end else begin
            oreg_wen_reg <= oreg_wen_next;
            m0_grant_reg <= issue && !sel_m1;
            m1_grant_reg <= issue && sel_m1;
            if (issue) begin
                oreg_reg    <= oreg_next;
                last_m1_reg <= sel_m1;
            end
        end
    end

    assign oreg     = oreg_reg;
    assign oreg_wen = oreg_wen_reg;
    assign m0_grant = m0_grant_reg;
    assign m1_grant = m1_grant_reg;

endmodule
